// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter driving a cdc_fifo write port
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     wr_clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       grant,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_data_in,
    output logic                     busy,
    output logic [15:0]              stall_cnt
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int BCNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state, state_nxt;
    logic [NUM_REQ-1:0]  grant_nxt;
    logic [PTR_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0]    owner, sel;
    logic [PTR_W:0]      idx;
    logic                sel_found;
    logic [BCNT_W-1:0]   burst_cnt, burst_nxt;
    logic [15:0]         stall_nxt;

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) owner = PTR_W'(i);
        end
    end

    // First requester at or after rr_ptr, wrapping past NUM_REQ-1 back to 0.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
            if (!sel_found && req[idx[PTR_W-1:0]]) begin
                sel       = idx[PTR_W-1:0];
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        rr_ptr_nxt   = rr_ptr;
        burst_nxt    = burst_cnt;
        stall_nxt    = stall_cnt;
        ack          = '0;
        fifo_wr_en   = 1'b0;
        fifo_data_in = '0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    grant_nxt = NUM_REQ'(1) << sel;
                    burst_nxt = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                fifo_data_in = req_data[int'(owner)*WIDTH +: WIDTH];
                if (req[owner] && !fifo_full) begin
                    ack[owner] = 1'b1;
                    fifo_wr_en = 1'b1;
                    if (burst_cnt == BCNT_W'(MAX_BURST - 1)) begin
                        state_nxt  = IDLE;
                        grant_nxt  = '0;
                        rr_ptr_nxt = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                    end else begin
                        burst_nxt = burst_cnt + 1'b1;
                    end
                end else if (req[owner]) begin
                    if (stall_cnt != 16'hFFFF) stall_nxt = stall_cnt + 16'd1;
                end else begin
                    state_nxt  = IDLE;
                    grant_nxt  = '0;
                    rr_ptr_nxt = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_nxt;
            stall_cnt <= stall_nxt;
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           wr_clk = 1'b0;
    logic           rst_n  = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic           fifo_full = 1'b0;
    logic [N-1:0]   ack, grant;
    logic           fifo_wr_en, busy;
    logic [W-1:0]   fifo_data_in;
    logic [15:0]    stall_cnt;

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .wr_clk(wr_clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .ack(ack), .grant(grant), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_data_in(fifo_data_in), .busy(busy), .stall_cnt(stall_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: owner index (-1 = nobody), words in burst, next search start, stalls.
    int m_owner, m_cnt, m_ptr, m_stall;

    typedef struct {
        logic [N-1:0] req;
        logic         full;
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_ack;
        logic         exp_busy;
        logic [15:0]  exp_stall;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        fifo_full = 1'b0;
        @(posedge wr_clk);
        @(posedge wr_clk);
        #1 rst_n = 1'b1;
        m_owner = -1; m_cnt = 0; m_ptr = 0; m_stall = 0;
    endtask

    function automatic logic [W-1:0] slice_of_onehot(input logic [N-1:0] oh);
        logic [W-1:0] r = '0;
        for (int i = 0; i < N; i++) if (oh[i]) r = req_data[i*W +: W];
        return r;
    endfunction

    task automatic model_check();
        logic [N-1:0] eg, ea;
        logic [W-1:0] ed;
        eg = (m_owner < 0) ? '0 : N'(1) << m_owner;
        ea = (m_owner >= 0 && req[m_owner] && !fifo_full) ? eg : '0;
        ed = (m_owner < 0) ? '0 : req_data[m_owner*W +: W];
        chk("rnd_grant", 32'(grant), 32'(eg));
        chk("rnd_ack", 32'(ack), 32'(ea));
        chk("rnd_wr_en", 32'(fifo_wr_en), 32'(|ea));
        chk("rnd_data", 32'(fifo_data_in), 32'(ed));
        chk("rnd_busy", 32'(busy), 32'(m_owner >= 0));
        chk("rnd_stall", 32'(stall_cnt), 32'(m_stall));
    endtask

    task automatic model_step();
        if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (m_owner < 0 && req[k]) begin
                    m_owner = k;
                    m_cnt = 0;
                end
            end
        end else if (!req[m_owner]) begin
            m_ptr = (m_owner + 1) % N;
            m_owner = -1;
        end else if (fifo_full) begin
            if (m_stall < 65535) m_stall++;
        end else if (m_cnt == MB - 1) begin
            m_ptr = (m_owner + 1) % N;
            m_owner = -1;
        end else begin
            m_cnt++;
        end
    endtask

    initial begin
        logic [W-1:0] got[$];
        int acks;
        int cyc;

        // Single requester 2, 3-cycle backpressure mid-burst, re-grant after bubble, then drop.
        vecs[0]  = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd0};
        vecs[1]  = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 16'd0};
        vecs[2]  = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 16'd0};
        vecs[3]  = '{4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 16'd0};
        vecs[4]  = '{4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 16'd1};
        vecs[5]  = '{4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 16'd2};
        vecs[6]  = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 16'd3};
        vecs[7]  = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 16'd3};
        vecs[8]  = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd3};
        vecs[9]  = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 16'd3};
        vecs[10] = '{4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b1, 16'd3};
        vecs[11] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd3};

        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        do_reset();
        for (int v = 0; v < 12; v++) begin
            req = vecs[v].req;
            fifo_full = vecs[v].full;
            @(negedge wr_clk);
            chk($sformatf("vec%0d_grant", v), 32'(grant), 32'(vecs[v].exp_grant));
            chk($sformatf("vec%0d_ack", v), 32'(ack), 32'(vecs[v].exp_ack));
            chk($sformatf("vec%0d_wr_en", v), 32'(fifo_wr_en), 32'(|vecs[v].exp_ack));
            chk($sformatf("vec%0d_data", v), 32'(fifo_data_in), 32'(slice_of_onehot(vecs[v].exp_grant)));
            chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
            chk($sformatf("vec%0d_stall", v), 32'(stall_cnt), 32'(vecs[v].exp_stall));
            tick();
        end

        // All requesting: four words each in order 0,1,2,3,0.
        do_reset();
        req = 4'b1111;
        cyc = 0;
        while (got.size() < 20 && cyc < 60) begin
            @(negedge wr_clk);
            if (fifo_wr_en) got.push_back(fifo_data_in);
            tick();
            cyc++;
        end
        chk("all_req_count", 32'(got.size()), 32'd20);
        for (int k = 0; k < got.size(); k++)
            chk($sformatf("all_req_word%0d", k), 32'(got[k]), 32'(8'h10 + 8'h11 * ((k / 4) % 4)));

        // Early drop by requester 1 after two acks; next grant goes to 3.
        do_reset();
        req = 4'b0010;
        tick(); tick();
        @(negedge wr_clk); chk("drop_ack2", 32'(ack), 32'(4'b0010));
        tick();
        req = 4'b0000;
        @(negedge wr_clk);
        chk("drop_grant_held", 32'(grant), 32'(4'b0010));
        chk("drop_no_ack", 32'(ack), 32'd0);
        tick();
        req = 4'b1010;
        @(negedge wr_clk); chk("drop_bubble", 32'(busy), 32'd0);
        tick();
        @(negedge wr_clk); chk("drop_next_grant", 32'(grant), 32'(4'b1000));
        tick();

        // Reset mid-burst: outputs drop at once; burst restarts cleanly.
        do_reset();
        req = 4'b0001;
        tick(); tick();
        fifo_full = 1'b1;
        tick();
        fifo_full = 1'b0;
        @(negedge wr_clk); chk("rst_2nd_ack", 32'(ack), 32'(4'b0001));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_data", 32'(fifo_data_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        req = 4'b1000;
        tick();
        @(negedge wr_clk); chk("rst_low_wr_en", 32'(fifo_wr_en), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge wr_clk); chk("rst_regrant", 32'(grant), 32'(4'b1000));
        acks = 0;
        cyc = 0;
        while (busy && cyc < 12) begin
            if (ack == 4'b1000) acks++;
            tick();
            @(negedge wr_clk);
            cyc++;
        end
        chk("rst_burst_len", 32'(acks), 32'(MB));
        tick();

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(5) == 0) req[b] = ~req[b];
            fifo_full = ($urandom_range(3) == 0);
            req_data = $urandom;
            @(negedge wr_clk);
            model_check();
            model_step();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
